// File: rtl/cnn_layer_scheduler.sv
// Network-level scheduler for the CNN accelerator.
// Sequences layers, output channels and input channels.
module cnn_layer_scheduler #(
  parameter int NUM_LAYERS = 3,
  parameter int LW         = 2,
  parameter int ICW        = 4,
  parameter int OCW        = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [LW-1:0]  cfg_layer,
  input  logic [ICW-1:0] cfg_ic,
  input  logic [OCW-1:0] cfg_oc,
  input  logic           cfg_pool,
  input  logic           start,
  input  logic           ld_ack,
  input  logic           conv_done,
  input  logic           pool_done,
  output logic           busy,
  output logic           done,
  output logic           ld_req,
  output logic           conv_start,
  output logic           acc_en,
  output logic           acc_clr,
  output logic           out_wr,
  output logic           pool_start,
  output logic [LW-1:0]  layer_idx,
  output logic [ICW-1:0] ic_idx,
  output logic [OCW-1:0] oc_idx
);

  localparam int NE = 1 << LW;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_CONV_GO   = 4'd2;
  localparam logic [3:0] S_CONV_WAIT = 4'd3;
  localparam logic [3:0] S_ACC       = 4'd4;
  localparam logic [3:0] S_WRITE     = 4'd5;
  localparam logic [3:0] S_POOL_GO   = 4'd6;
  localparam logic [3:0] S_POOL_WAIT = 4'd7;
  localparam logic [3:0] S_NEXT      = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  localparam logic [LW-1:0] LAST_L = LW'(NUM_LAYERS - 1);

  logic [3:0]     state_q, state_d;
  logic [LW-1:0]  layer_q, layer_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [OCW-1:0] oc_q, oc_d;

  logic [ICW-1:0] ic_cfg_q [NE];
  logic [OCW-1:0] oc_cfg_q [NE];
  logic [NE-1:0]  pool_cfg_q;

  logic           cfg_ok;
  logic [ICW-1:0] ic_last;
  logic [OCW-1:0] oc_last;
  logic           pool_cur;

  assign cfg_ok = cfg_we && (state_q == S_IDLE)
               && (32'(cfg_layer) < NUM_LAYERS);

  assign ic_last  = ic_cfg_q[layer_q] - ICW'(1);
  assign oc_last  = oc_cfg_q[layer_q] - OCW'(1);
  assign pool_cur = pool_cfg_q[layer_q];

  // Per-layer config file; zero counts are stored as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        ic_cfg_q[i] <= ICW'(1);
        oc_cfg_q[i] <= OCW'(1);
      end
      pool_cfg_q <= '0;
    end else if (cfg_ok) begin
      ic_cfg_q[cfg_layer] <= (cfg_ic == '0) ? ICW'(1) : cfg_ic;
      oc_cfg_q[cfg_layer] <= (cfg_oc == '0) ? OCW'(1) : cfg_oc;
      pool_cfg_q[cfg_layer] <= cfg_pool;
    end
  end

  // Next-state and loop-index logic.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    ic_d    = ic_q;
    oc_d    = oc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          layer_d = '0;
          ic_d    = '0;
          oc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_ack) state_d = S_CONV_GO;
      end
      S_CONV_GO: state_d = S_CONV_WAIT;
      S_CONV_WAIT: begin
        if (conv_done) state_d = S_ACC;
      end
      S_ACC: begin
        if (ic_q == ic_last) begin
          state_d = S_WRITE;
        end else begin
          ic_d    = ic_q + ICW'(1);
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        if (oc_q == oc_last) begin
          state_d = pool_cur ? S_POOL_GO : S_NEXT;
        end else begin
          oc_d    = oc_q + OCW'(1);
          ic_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_POOL_GO: state_d = S_POOL_WAIT;
      S_POOL_WAIT: begin
        if (pool_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (layer_q == LAST_L) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + LW'(1);
          ic_d    = '0;
          oc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign ld_req     = (state_q == S_LOAD);
  assign conv_start = (state_q == S_CONV_GO);
  assign acc_en     = (state_q == S_ACC);
  assign acc_clr    = (state_q == S_ACC) && (ic_q == '0);
  assign out_wr     = (state_q == S_WRITE);
  assign pool_start = (state_q == S_POOL_GO);
  assign layer_idx  = layer_q;
  assign ic_idx     = ic_q;
  assign oc_idx     = oc_q;

endmodule

// File: doc/cnn_layer_scheduler.md
Name: cnn_layer_scheduler

Overview:
- Network-level scheduler for the CNN accelerator. It runs NUM_LAYERS convolution layers back to back on the shared conv engine, adder tree, output writer and pooling unit.
- For each layer it loops over output channels and, inside that, over input channels. Per input channel it issues channel-load, conv-start and accumulate steps; per output channel it issues an output write. It then optionally pools, and moves to the next layer.
- Per-layer channel counts and pool enable come from a small config register file, written while idle.

Parameters:
- NUM_LAYERS, 3: number of layers sequenced per run (at least 1).
- LW, 2: layer index width; must satisfy 2^LW >= NUM_LAYERS.
- ICW, 4: input-channel count/index width.
- OCW, 6: output-channel count/index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cfg_we  in  1  config write strobe.
- cfg_layer  in  LW  layer being configured.
- cfg_ic  in  ICW  input-channel count for that layer.
- cfg_oc  in  OCW  output-channel count for that layer.
- cfg_pool  in  1  pool enable for that layer.
- start  in  1  run request, single-cycle pulse.
- ld_ack  in  1  channel loader accepted the request.
- conv_done  in  1  conv engine finished the current channel.
- pool_done  in  1  pooling unit finished.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- ld_req  out  1  channel-load request (level).
- conv_start  out  1  conv engine start pulse.
- acc_en  out  1  adder-tree accumulate strobe.
- acc_clr  out  1  qualifies acc_en: load instead of add (first input channel).
- out_wr  out  1  write accumulated output channel.
- pool_start  out  1  pooling start pulse.
- layer_idx  out  LW  current layer.
- ic_idx  out  ICW  current input channel.
- oc_idx  out  OCW  current output channel.

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block is clocked on clk.
- On reset:
  - State goes to IDLE.
  - All outputs are 0 and all indices are 0.
  - Every config entry resets to ic=1, oc=1, pool=0.
- Reset asserted mid-run aborts immediately. No done pulse is issued.
- Config:
  - A write on cfg_we is taken only in IDLE; writes while busy are ignored.
  - cfg_layer >= NUM_LAYERS is ignored.
  - A count of 0 is stored as 1.
- Outputs are decoded from the registered state, so each is valid in the cycle that state is held.
- States and transitions:
  - IDLE: busy=0. On start, clear all indices and go to LOAD. busy=1 from the next cycle.
  - LOAD: ld_req=1. Held until ld_ack is sampled high, then go to CONV_GO. An ack in the first LOAD cycle is accepted.
  - CONV_GO: conv_start=1 for exactly one cycle, then go to CONV_WAIT. conv_done is ignored in this state.
  - CONV_WAIT: wait for conv_done, then go to ACC.
  - ACC: acc_en=1 for one cycle, with acc_clr=(ic_idx==0).
    - If ic_idx == ic_cfg-1, go to WRITE.
    - Otherwise increment ic_idx and go to LOAD.
  - WRITE: out_wr=1 for one cycle.
    - If oc_idx == oc_cfg-1, go to POOL_GO if pool_cfg=1, else to NEXT.
    - Otherwise increment oc_idx, clear ic_idx, and go to LOAD.
  - POOL_GO: pool_start=1 for one cycle, then go to POOL_WAIT.
  - POOL_WAIT: wait for pool_done, then go to NEXT.
  - NEXT:
    - If layer_idx == NUM_LAYERS-1, go to DONE.
    - Otherwise increment layer_idx, clear ic_idx and oc_idx, and go to LOAD.
  - DONE: done=1 and busy=1 for one cycle, then go to IDLE. Indices hold their final values until the next start.
- The config for the current layer is read combinationally, indexed by layer_idx.
- start is ignored while busy, including in the DONE cycle.
- Stray ld_ack, conv_done or pool_done in any other state is ignored.
- Index compares are on exact equality, so an index never wraps past its configured count.
- Minimum cycles per input channel is 4 (LOAD, CONV_GO, CONV_WAIT, ACC), with ld_ack immediate and conv_done in the first CONV_WAIT cycle.
- At most one of ld_req, conv_start, acc_en, out_wr, pool_start, done is high in any cycle.

Test Plan:
- Reset defaults, one layer active:
  - Stimulus: NUM_LAYERS=1; no config writes after reset; start; immediate acks.
  - Required: exactly 1 conv_start, 1 acc_en with acc_clr=1, 1 out_wr, no pool_start, then a done pulse. Total busy = 7 cycles.
- Channel loops, all three layers configured:
  - Stimulus: layer0 configured ic=3, oc=2, pool=1; layers 1 and 2 left at reset defaults.
  - Required:
    - Layer 0: 6 conv_start pulses; acc_clr=1 only on ic_idx=0 (2 times); out_wr at oc_idx 0 and 1; one pool_start.
    - Layer 0 then waits in POOL_WAIT until pool_done, which arrives 5 cycles after pool_start.
    - Layers 1 and 2: 1 conv_start and 1 out_wr each.
    - Run ends with a single done pulse.
- Handshake stalls: ld_ack delayed 3 cycles and conv_done delayed 10 cycles.
  - Required: ld_req stays high for exactly 4 cycles.
  - Required: conv_start is one cycle only.
  - Required: no acc_en until conv_done.
  - Required: a conv_done injected during CONV_GO is ignored.
- Config guard:
  - Stimulus: write cfg_ic=5 while busy; write cfg_ic=0 while idle.
  - Required: the busy-time write has no effect; the next run performs 1 input channel.
- Protocol robustness: start pulsed mid-run and during DONE.
  - Required: no restart.
  - Required: a later start after IDLE runs the full sequence again from layer 0.
- Reset mid-run:
  - Stimulus: rst_n low while in CONV_WAIT of layer 1.
  - Required: all outputs 0 immediately, no done pulse.
  - Required: config returns to defaults (ic=1, oc=1, pool=0).
